// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: fetch/decode/execute sequencer owning PC and IR for the 8-bit 4-register core
// Ports: clk, rst (async, active-high); cpu_tick_i step enable; run_mode_i 1=free run, 0=pause per instr;
//   step_req_i releases one instruction from PAUSE; mem_addr_o/mem_data_i program BRAM (1-clk latency);
//   pc_o, ir_o, operand_o architectural registers; reg_we_o one-hot write strobe; instr_done_o retire pulse;
//   halted_o core stopped at HALT_ADDR; state_dbg_o FSM state for the display mux
module cpu_seq_ctrl #(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter logic [7:0] HALT_ADDR = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_tick_i,
  input  logic       run_mode_i,
  input  logic       step_req_i,
  output logic [7:0] mem_addr_o,
  input  logic [7:0] mem_data_i,
  output logic [7:0] pc_o,
  output logic [7:0] ir_o,
  output logic [7:0] operand_o,
  output logic [3:0] reg_we_o,
  output logic       instr_done_o,
  output logic       halted_o,
  output logic [2:0] state_dbg_o
);
  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    OPWAIT  = 3'd2,
    OPERAND = 3'd3,
    EXEC    = 3'd4,
    PAUSE   = 3'd5,
    HALT    = 3'd6
  } state_t;
  state_t state_q, state_d;
  logic [7:0] pc_q, pc_d, ir_q, ir_d, op_q, op_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      op_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      op_q    <= op_d;
    end
  end
  // PAUSE watches step_req every clk; all other states move only on cpu_tick
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    op_d    = op_q;
    if (state_q == PAUSE) state_d = step_req_i ? FETCH : PAUSE;
    else if (cpu_tick_i) begin
      case (state_q)
        FETCH:   state_d = (pc_q == HALT_ADDR) ? HALT : DECODE;
        DECODE: begin
          ir_d    = mem_data_i;
          pc_d    = pc_q + 8'd1;
          state_d = (mem_data_i[7:5] == 3'b010) ? OPWAIT : EXEC;
        end
        OPWAIT:  state_d = OPERAND;
        OPERAND: begin
          op_d    = mem_data_i;
          pc_d    = ir_q[1] ? mem_data_i : pc_q + 8'd1;
          state_d = ir_q[1] ? (run_mode_i ? FETCH : PAUSE) : EXEC;
        end
        EXEC:    state_d = run_mode_i ? FETCH : PAUSE;
        default: state_d = state_q;
      endcase
    end
  end
  // strobes are combinational so the datapath commits on the same tick edge that retires
  always_comb begin
    reg_we_o     = (state_q == EXEC && cpu_tick_i) ? 4'b0001 << ir_q[3:2] : 4'b0000;
    instr_done_o = cpu_tick_i && (state_q == EXEC || (state_q == OPERAND && ir_q[1]));
    halted_o     = state_q == HALT;
  end
  assign mem_addr_o  = pc_q;
  assign pc_o        = pc_q;
  assign ir_o        = ir_q;
  assign operand_o   = op_q;
  assign state_dbg_o = state_q;
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: scoreboard bench for cpu_seq_ctrl against an instruction-level reference model
module tb_cpu_seq_ctrl;
  logic clk = 0, rst = 1, cpu_tick_i = 0, run_mode_i = 1, step_req_i = 0;
  logic [7:0] mem_data_i, mem_addr_o, pc_o, ir_o, operand_o;
  logic [3:0] reg_we_o;
  logic instr_done_o, halted_o;
  logic [2:0] state_dbg_o;
  logic [7:0] mem [256];
  typedef struct {logic [7:0] ir, op, pc_next; logic [3:0] we; int ticks;} exp_t;
  exp_t q[$];
  exp_t me;
  int cmp = 0, bad = 0, tcnt = 0;
  bit pend = 0;
  logic [7:0] pend_pc, pend_op, m_pc, m_op;
  bit m_halt;

  cpu_seq_ctrl dut (
    .clk(clk), .rst(rst), .cpu_tick_i(cpu_tick_i), .run_mode_i(run_mode_i), .step_req_i(step_req_i),
    .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i), .pc_o(pc_o), .ir_o(ir_o), .operand_o(operand_o),
    .reg_we_o(reg_we_o), .instr_done_o(instr_done_o), .halted_o(halted_o), .state_dbg_o(state_dbg_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_data_i <= mem[mem_addr_o];

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    cmp++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // architectural model: one instruction per call iteration, straight from the ISA rules
  task automatic model(int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      logic [7:0] b;
      if (m_pc == 8'h80) break;
      b = mem[m_pc];
      e.ir = b;
      if (b[7:5] == 3'd2) begin
        m_op = mem[m_pc + 8'd1];
        if (b[1]) begin e.we = 4'b0000; e.pc_next = m_op; e.ticks = 4; end
        else begin e.we = 4'b0001 << b[3:2]; e.pc_next = m_pc + 8'd2; e.ticks = 5; end
      end else begin
        e.we = 4'b0001 << b[3:2]; e.pc_next = m_pc + 8'd1; e.ticks = 3;
      end
      e.op = m_op;
      q.push_back(e);
      m_pc = e.pc_next;
    end
    if (m_pc == 8'h80) m_halt = 1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      tcnt = 0;
      pend = 0;
    end else begin
      if (pend) begin
        chk("pc_after", pc_o, pend_pc);
        chk("mem_addr", mem_addr_o, pend_pc);
        chk("operand", operand_o, pend_op);
        pend = 0;
      end
      if (step_req_i && !run_mode_i) tcnt = 0;
      else if (cpu_tick_i) tcnt++;
      if (instr_done_o) begin
        if (q.size() == 0) begin
          cmp++;
          bad++;
          $display("FAIL spurious_retire: instr_done=1 with none expected, pc=%0h (t=%0t)", pc_o, $time);
        end else begin
          me = q.pop_front();
          chk("ir", ir_o, me.ir);
          chk("reg_we", reg_we_o, me.we);
          chk("latency", tcnt, me.ticks);
          pend = 1;
          pend_pc = me.pc_next;
          pend_op = me.op;
        end
        tcnt = 0;
      end else if (reg_we_o != 4'b0000) chk("reg_we_idle", reg_we_o, 0);
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; cpu_tick_i = 0; step_req_i = 0;
    q.delete(); m_pc = 8'h00; m_op = 8'h00; m_halt = 0;
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic run(int pct, int sp, int budget);
    int c = 0;
    while (q.size() != 0 && c < budget) begin
      @(posedge clk); #1;
      cpu_tick_i = ($urandom_range(99) < pct);
      step_req_i = ($urandom_range(99) < sp);
      c++;
    end
    cpu_tick_i = 0;
    step_req_i = 0;
    if (q.size() != 0) begin
      cmp++;
      bad++;
      $display("FAIL retire_timeout: %0d instructions outstanding, expected 0", q.size());
      q.delete();
    end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic halt_chk();
    repeat (10) begin
      @(posedge clk); #1;
      cpu_tick_i = 1;
      step_req_i = 1'($urandom_range(1));
    end
    @(posedge clk); #1;
    cpu_tick_i = 0; step_req_i = 0;
    chk("halted", halted_o, 1);
    chk("halt_pc", pc_o, 8'h80);
    chk("halt_state", state_dbg_o, 6);
    chk("halt_we", reg_we_o, 0);
  endtask

  task automatic load(logic [7:0] a0, logic [7:0] a1, logic [7:0] aff);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = a0; mem[1] = a1; mem[255] = aff;
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    int c;
    load(8'h24, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc_o, 0);
    chk("rst_ir", ir_o, 0);
    chk("rst_operand", operand_o, 0);
    chk("rst_we", reg_we_o, 0);
    chk("rst_done", instr_done_o, 0);
    chk("rst_halted", halted_o, 0);
    chk("rst_state", state_dbg_o, 0);
    rst = 0;
    m_pc = 0; m_op = 0; m_halt = 0;
    // one-byte add to R1
    model(1); run(100, 0, 50);
    // two-byte load immediate to R2
    load(8'h48, 8'h5A, 8'h00); do_reset(); model(1); run(100, 0, 50);
    // jump to 10
    load(8'h42, 8'h10, 8'h00); do_reset(); model(1); run(100, 0, 50);
    // jump to HALT_ADDR then halt
    load(8'h42, 8'h80, 8'h00); do_reset(); model(2); run(100, 0, 50);
    chk("model_halt", m_halt, 1);
    halt_chk();
    // pc wrap FF -> 00
    load(8'h42, 8'hFF, 8'h2C); do_reset(); model(2); run(70, 30, 100);
    // random programs, free run with random ticks and ignored step pulses
    repeat (4) begin
      rand_mem(); do_reset(); model(20); run(60, 20, 2000);
      if (m_halt) halt_chk();
    end
    // pause / single-step
    run_mode_i = 0;
    repeat (2) begin
      rand_mem(); do_reset();
      for (int k = 0; k < 5; k++) begin
        if (m_halt) break;
        model(1);
        if (q.size() == 0) break;
        run(60, 0, 200);
        repeat (10) begin @(posedge clk); #1 cpu_tick_i = 1; end
        cpu_tick_i = 0;
        chk("pause_state", state_dbg_o, 5);
        @(posedge clk); #1 step_req_i = 1;
        @(posedge clk); #1 step_req_i = 0;
      end
    end
    run_mode_i = 1;
    // async reset during OPERAND
    load(8'h48, 8'h5A, 8'h00); do_reset();
    cpu_tick_i = 1; c = 0;
    while (state_dbg_o != 3'd3 && c < 20) begin @(posedge clk); #1; c++; end
    chk("reach_operand", state_dbg_o, 3);
    #1 rst = 1;
    #1;
    chk("abort_pc", pc_o, 0);
    chk("abort_state", state_dbg_o, 0);
    chk("abort_we", reg_we_o, 0);
    // async reset during EXEC with tick high suppresses the strobe at once
    load(8'h24, 8'h00, 8'h00); do_reset();
    cpu_tick_i = 1; c = 0;
    while (state_dbg_o != 3'd4 && c < 20) begin @(posedge clk); #1; c++; end
    chk("exec_we", reg_we_o, 4'b0010);
    #1 rst = 1;
    #1;
    chk("abort_exec_we", reg_we_o, 0);
    chk("abort_exec_done", instr_done_o, 0);
    cpu_tick_i = 0;
    @(posedge clk); #1 rst = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
